// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU.
// ALUControl code points, FSM state encoding and the shift-amount width helper.
package alu_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLL = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SRL = 3'b110;
   localparam logic [2:0] ALU_MUL = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } alu_state_t;

   // Number of operand-B bits that form the shift amount for a given width.
   function automatic int shamt_width(input int width);
      return $clog2(width);
   endfunction

   localparam int ALU_SHAMT_W = shamt_width(32);

endpackage

// File: rtl/alu_seq_core.sv
// alu_seq_core: iterative datapath for the multi-cycle ALU operations.
// Shifts move the accumulator one bit per step; the multiply (only when
// ALU_MUL_EN is defined) performs one shift-add step per cycle.
// acc_next is the value the accumulator takes on the current step, so the
// top level can register the final result on the same edge as the last step.
module alu_seq_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          step,
   input  logic                          op_mul,
   input  logic                          op_right,
   input  logic [WIDTH-1:0]              a,
   input  logic [WIDTH-1:0]              b,
   input  logic [shamt_width(WIDTH)-1:0] shamt,
   output logic [WIDTH-1:0]              acc_next,
   output logic                          last
);

   localparam int SHW = shamt_width(WIDTH);
   localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);
   localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);

   logic [WIDTH-1:0] acc_reg;
   logic [SHW:0]     cnt_reg;
   logic             right_reg;

   assign last = (cnt_reg == CNT_ONE);

   // Accumulator and remaining-step counter: load on start, advance on step.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_reg   <= '0;
         cnt_reg   <= '0;
         right_reg <= 1'b0;
      end else if (start) begin
         acc_reg   <= op_mul ? '0 : a;
         cnt_reg   <= op_mul ? CNT_MUL : {1'b0, shamt};
         right_reg <= op_right;
      end else if (step) begin
         acc_reg <= acc_next;
         cnt_reg <= cnt_reg - CNT_ONE;
      end
   end

`ifdef ALU_MUL_EN
   logic             mul_reg;
   logic [WIDTH-1:0] mcand_reg;
   logic [WIDTH-1:0] mplier_reg;

   // Multiplicand walks left and multiplier walks right, one bit per step.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mul_reg    <= 1'b0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
      end else if (start) begin
         mul_reg    <= op_mul;
         mcand_reg  <= a;
         mplier_reg <= b;
      end else if (step && mul_reg) begin
         mcand_reg  <= mcand_reg << 1;
         mplier_reg <= mplier_reg >> 1;
      end
   end

   // Next accumulator value: conditional add for multiply, 1-bit shift otherwise.
   always_comb begin
      acc_next = right_reg ? (acc_reg >> 1) : (acc_reg << 1);
      if (mul_reg) begin
         acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
      end
   end
`else
   // Operand B only feeds the multiplier, which is absent in this build.
   logic unused_b;
   assign unused_b = ^b;

   // Next accumulator value: 1-bit shift in the selected direction.
   always_comb begin
      acc_next = right_reg ? (acc_reg >> 1) : (acc_reg << 1);
   end
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready on both sides.
// Logic ops, add/sub and SLT finish in one cycle; shifts and the optional
// multiply iterate in alu_seq_core.  Defining ALU_MUL_EN enables the serial
// multiply for code 111; otherwise code 111 returns 0 with Illegal set.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       ALUControl,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             Negative,
   output logic             Carry,
   output logic             Overflow,
   output logic             Illegal
);

   localparam int SHW = shamt_width(WIDTH);

   alu_state_t       state_reg;
   alu_state_t       state_next;
   logic             accept;
   logic             needs_seq;
   logic             start_seq;
   logic             step_seq;
   logic             finish_seq;
   logic [SHW-1:0]   shamt;
   logic             is_shift;
   logic             is_sub;
   logic [WIDTH-1:0] b_op;
   logic [WIDTH:0]   sum;
   logic             add_v;
   logic [WIDTH-1:0] res_single;
   logic             c_single;
   logic             v_single;
   logic             ill_single;
   logic [WIDTH-1:0] seq_acc_next;
   logic             seq_last;

   assign shamt    = SrcB[SHW-1:0];
   assign is_shift = (ALUControl == ALU_SLL) || (ALUControl == ALU_SRL);
   assign is_sub   = (ALUControl == ALU_SUB) || (ALUControl == ALU_SLT);
   assign b_op     = is_sub ? ~SrcB : SrcB;
   assign sum      = {1'b0, SrcA} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
   assign add_v    = (SrcA[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);

`ifdef ALU_MUL_EN
   assign needs_seq = (ALUControl == ALU_MUL) || (is_shift && (shamt != '0));
`else
   assign needs_seq = is_shift && (shamt != '0);
`endif

   assign out_valid = (state_reg == ST_DONE);

   // Single-cycle result and flags for the code on the inputs.
   always_comb begin
      res_single = '0;
      c_single   = 1'b0;
      v_single   = 1'b0;
      ill_single = 1'b0;
      case (ALUControl)
         ALU_ADD, ALU_SUB: begin
            res_single = sum[WIDTH-1:0];
            c_single   = sum[WIDTH];
            v_single   = add_v;
         end
         ALU_AND: res_single = SrcA & SrcB;
         ALU_OR:  res_single = SrcA | SrcB;
         ALU_SLT: res_single = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_v};
         ALU_SLL, ALU_SRL: res_single = SrcA;  // shift by zero
`ifdef ALU_MUL_EN
         ALU_MUL: res_single = '0;             // always iterated
`else
         ALU_MUL: ill_single = 1'b1;
`endif
         default: res_single = '0;
      endcase
   end

   // Next state and handshake; a finishing DONE can accept in the same cycle.
   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      step_seq   = 1'b0;
      finish_seq = 1'b0;
      case (state_reg)
         ST_IDLE: in_ready = 1'b1;
         ST_BUSY: begin
            step_seq = 1'b1;
            if (seq_last) begin
               finish_seq = 1'b1;
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            in_ready = out_ready;
            if (out_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
      accept    = in_valid && in_ready;
      start_seq = accept && needs_seq;
      if (accept) state_next = needs_seq ? ST_BUSY : ST_DONE;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= ST_IDLE;
      else      state_reg <= state_next;
   end

   // Result and flag registers, written only when a result is produced.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         Result   <= '0;
         Zero     <= 1'b0;
         Negative <= 1'b0;
         Carry    <= 1'b0;
         Overflow <= 1'b0;
         Illegal  <= 1'b0;
      end else if (accept && !needs_seq) begin
         Result   <= res_single;
         Zero     <= (res_single == '0);
         Negative <= res_single[WIDTH-1];
         Carry    <= c_single;
         Overflow <= v_single;
         Illegal  <= ill_single;
      end else if (finish_seq) begin
         Result   <= seq_acc_next;
         Zero     <= (seq_acc_next == '0);
         Negative <= seq_acc_next[WIDTH-1];
         Carry    <= 1'b0;
         Overflow <= 1'b0;
         Illegal  <= 1'b0;
      end
   end

   alu_seq_core #(.WIDTH(WIDTH)) u_seq (
      .clk      (clk),
      .rst      (rst),
      .start    (start_seq),
      .step     (step_seq),
      .op_mul   (ALUControl == ALU_MUL),
      .op_right (ALUControl == ALU_SRL),
      .a        (SrcA),
      .b        (SrcB),
      .shamt    (shamt),
      .acc_next (seq_acc_next),
      .last     (seq_last)
   );

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed self-checking bench for alu_exec_unit.
// Honours ALU_MUL_EN the same way as the design.
module tb_alu_exec_unit;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  ALUControl;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Result;
   logic        Zero, Negative, Carry, Overflow, Illegal;
   logic [4:0]  flg;

   int n_checks = 0;
   int n_fail   = 0;

   assign flg = {Zero, Negative, Carry, Overflow, Illegal};

   always #5 clk = ~clk;

   alu_exec_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB),
      .out_valid(out_valid), .out_ready(out_ready), .Result(Result),
      .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow),
      .Illegal(Illegal)
   );

   // Issue one request, scramble inputs after the accept edge, wait for the result.
   task automatic do_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic saw_ready);
      ALUControl = code; SrcA = a; SrcB = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; ALUControl = code ^ 3'b011; SrcA = ~a; SrcB = b ^ 32'h5A5A_A5A5;
      lat = 1; saw_ready = 1'b0;
      while (!out_valid && lat < 100) begin
         saw_ready |= in_ready;
         @(posedge clk); #1;
         lat++;
      end
      $display("op code=%b a=%h b=%h -> result=%h flags(ZNCVI)=%b latency=%0d",
               code, a, b, Result, flg, lat);
   endtask

   task automatic test_reset;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      ALUControl = 3'b000; SrcA = '0; SrcB = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if ({Result, flg} !== 37'h0) begin n_fail++; $display("FAIL reset_outputs: got %h/%b want 0/00000", Result, flg); end
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_addsub;
      int lat; logic sr;
      do_op(ALU_ADD, 32'h7FFF_FFFF, 32'h1, lat, sr);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d want 1", lat); end
      n_checks++; if (Result !== 32'h8000_0000) begin n_fail++; $display("FAIL add_ovf_result: got %h want 80000000", Result); end
      n_checks++; if (flg !== 5'b01010) begin n_fail++; $display("FAIL add_ovf_flags: got %b want 01010", flg); end
      do_op(ALU_ADD, 32'hFFFF_FFFF, 32'h1, lat, sr);
      n_checks++; if ({Result, flg} !== {32'h0, 5'b10100}) begin n_fail++; $display("FAIL add_carry: got %h/%b want 0/10100", Result, flg); end
      do_op(ALU_SUB, 32'd5, 32'd5, lat, sr);
      n_checks++; if ({Result, flg} !== {32'h0, 5'b10100}) begin n_fail++; $display("FAIL sub_equal: got %h/%b want 0/10100", Result, flg); end
      do_op(ALU_SUB, 32'd3, 32'd5, lat, sr);
      n_checks++; if ({Result, flg} !== {32'hFFFF_FFFE, 5'b01000}) begin n_fail++; $display("FAIL sub_borrow: got %h/%b want fffffffe/01000", Result, flg); end
   endtask

   task automatic test_slt_logic;
      int lat; logic sr;
      do_op(ALU_SLT, 32'hFFFF_FFFF, 32'h1, lat, sr);
      n_checks++; if ({Result, flg} !== {32'h1, 5'b00000}) begin n_fail++; $display("FAIL slt_neg: got %h/%b want 1/00000", Result, flg); end
      do_op(ALU_SLT, 32'h1, 32'hFFFF_FFFF, lat, sr);
      n_checks++; if ({Result, flg} !== {32'h0, 5'b10000}) begin n_fail++; $display("FAIL slt_pos: got %h/%b want 0/10000", Result, flg); end
      do_op(ALU_SLT, 32'h8000_0000, 32'h1, lat, sr);
      n_checks++; if (Result !== 32'h1) begin n_fail++; $display("FAIL slt_ovf: got %h want 1", Result); end
      do_op(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, lat, sr);
      n_checks++; if ({Result, flg} !== {32'h00F0_1234, 5'b00000}) begin n_fail++; $display("FAIL and: got %h/%b want 00f01234/00000", Result, flg); end
      do_op(ALU_OR, 32'h8000_0001, 32'h0000_0100, lat, sr);
      n_checks++; if ({Result, flg} !== {32'h8000_0101, 5'b01000}) begin n_fail++; $display("FAIL or: got %h/%b want 80000101/01000", Result, flg); end
   endtask

   task automatic test_shift;
      int lat; logic sr;
      do_op(ALU_SLL, 32'h1, 32'd31, lat, sr);
      n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL sll31_latency: got %0d want 32", lat); end
      n_checks++; if ({Result, flg} !== {32'h8000_0000, 5'b01000}) begin n_fail++; $display("FAIL sll31_result: got %h/%b want 80000000/01000", Result, flg); end
      n_checks++; if (sr !== 1'b0) begin n_fail++; $display("FAIL sll31_in_ready_busy: got %b want 0", sr); end
      do_op(ALU_SRL, 32'h8000_0000, 32'd4, lat, sr);
      n_checks++; if ({lat[7:0], Result} !== {8'd5, 32'h0800_0000}) begin n_fail++; $display("FAIL srl4: got lat %0d %h want 5 08000000", lat, Result); end
      do_op(ALU_SLL, 32'hF000_0001, 32'hFFFF_FFE3, lat, sr);
      n_checks++; if ({lat[7:0], Result} !== {8'd4, 32'h8000_0008}) begin n_fail++; $display("FAIL sll3_upper_b: got lat %0d %h want 4 80000008", lat, Result); end
      do_op(ALU_SRL, 32'hDEAD_BEEF, 32'h20, lat, sr);
      n_checks++; if ({lat[7:0], Result, flg} !== {8'd1, 32'hDEAD_BEEF, 5'b01000}) begin n_fail++; $display("FAIL srl0: got lat %0d %h/%b want 1 deadbeef/01000", lat, Result, flg); end
   endtask

   task automatic test_mul;
      int lat; logic sr;
`ifdef ALU_MUL_EN
      do_op(ALU_MUL, 32'd12345, 32'd6789, lat, sr);
      n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL mul_latency: got %0d want 33", lat); end
      n_checks++; if ({Result, flg} !== {32'd83810205, 5'b00000}) begin n_fail++; $display("FAIL mul_result: got %0d/%b want 83810205/00000", Result, flg); end
      do_op(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, sr);
      n_checks++; if (Result !== 32'h1) begin n_fail++; $display("FAIL mul_wrap: got %h want 1", Result); end
`else
      do_op(ALU_MUL, 32'd12345, 32'd6789, lat, sr);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL mul_illegal_latency: got %0d want 1", lat); end
      n_checks++; if ({Result, flg} !== {32'h0, 5'b10001}) begin n_fail++; $display("FAIL mul_illegal: got %h/%b want 0/10001", Result, flg); end
`endif
   endtask

   task automatic test_hold_and_stream;
      int lat; logic sr;
      logic [36:0] held;
      @(posedge clk); #1;
      out_ready = 1'b0;
      do_op(ALU_AND, 32'h1234_5678, 32'h0F0F_0F0F, lat, sr);
      held = {Result, flg};
      n_checks++; if (held !== {32'h0204_0608, 5'b00000}) begin n_fail++; $display("FAIL hold_and: got %h want %h", held, {32'h0204_0608, 5'b00000}); end
      ALUControl = ALU_OR; SrcA = 32'h1; SrcB = 32'h100; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         $display("hold cycle %0d: valid=%b in_ready=%b result=%h flags=%b", i, out_valid, in_ready, Result, flg);
         n_checks++; if ({out_valid, in_ready, Result, flg} !== {2'b10, held}) begin n_fail++; $display("FAIL hold_stable: got %b%b %h/%b want 10 %h", out_valid, in_ready, Result, flg, held); end
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         SrcA = 32'h1 << i; SrcB = 32'h100 << i;
         @(posedge clk); #1;
         $display("stream %0d: valid=%b result=%h", i, out_valid, Result);
         n_checks++; if ({out_valid, Result} !== {1'b1, (32'h1 << i) | (32'h100 << i)}) begin n_fail++; $display("FAIL stream_or%0d: got %b/%h want 1/%h", i, out_valid, Result, (32'h1 << i) | (32'h100 << i)); end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_busy;
      int lat; logic sr; logic saw_valid;
`ifdef ALU_MUL_EN
      ALUControl = ALU_MUL; SrcA = 32'd12345; SrcB = 32'd6789;
`else
      ALUControl = ALU_SLL; SrcA = 32'h1; SrcB = 32'd31;
`endif
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      n_checks++; if ({out_valid, Result, flg} !== 38'h0) begin n_fail++; $display("FAIL mid_reset_outputs: got %b %h/%b want all 0", out_valid, Result, flg); end
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_in_ready: got %b want 1", in_ready); end
      saw_valid = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         saw_valid |= out_valid;
      end
      $display("after mid-busy reset: stray valid seen=%b", saw_valid);
      n_checks++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_stray_valid: got %b want 0", saw_valid); end
      do_op(ALU_ADD, 32'd2, 32'd3, lat, sr);
      n_checks++; if ({lat[7:0], Result} !== {8'd1, 32'd5}) begin n_fail++; $display("FAIL post_reset_add: got lat %0d %h want 1 5", lat, Result); end
   endtask

   initial begin
      test_reset();
      test_addsub();
      test_slt_logic();
      test_shift();
      test_mul();
      test_hold_and_stream();
      test_reset_mid_busy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
